// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: fetch PC owner with prefetch queue; define IFQ_BYPASS_EN for empty-queue response bypass
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          ADDR_W   = 12,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              w_redir,
  input  logic [31:0]       w_tpc,
  input  logic              w_halt,
  output logic [ADDR_W-1:0] w_iaddr,
  input  logic [31:0]       w_idata,
  output logic              w_dvalid,
  output logic [31:0]       w_dir,
  output logic [31:0]       w_dpc,
  output logic [31:0]       w_dpc4,
  input  logic              w_dready,
  output logic [31:0]       r_fpc
);
  localparam int PW = $clog2(DEPTH);
  logic [31:0]   r_ir  [DEPTH];
  logic [31:0]   r_pc  [DEPTH];
  logic [31:0]   r_pc4 [DEPTH];
  logic [PW-1:0] r_rp, r_wp;
  logic [PW:0]   r_cnt;
  logic          r_inf;
  logic [31:0]   r_ipc;
  logic [PW+1:0] w_occ;
  logic          w_deq, w_qdeq, w_enq, w_issue, w_byp;
`ifdef IFQ_BYPASS_EN
  assign w_byp = (r_cnt == '0) & r_inf & !w_redir;
`else
  assign w_byp = 1'b0;
`endif
  assign w_iaddr  = r_fpc[ADDR_W+1:2];
  assign w_dvalid = (r_cnt != '0) | w_byp;
  assign w_dir    = w_byp ? w_idata : r_ir[r_rp];
  assign w_dpc    = w_byp ? r_ipc : r_pc[r_rp];
  assign w_dpc4   = w_byp ? r_ipc + 32'd4 : r_pc4[r_rp];
  assign w_deq    = w_dvalid & w_dready;
  assign w_qdeq   = w_deq & !w_byp;
  // a bypassed response that decode takes this cycle never occupies a slot
  assign w_enq    = r_inf & !w_redir & !(w_byp & w_dready);
  // occupancy after this cycle, counting the reserved slot of the in-flight fetch
  assign w_occ    = {1'b0, r_cnt} + (PW+2)'(r_inf) - (PW+2)'(w_deq);
  assign w_issue  = !w_halt & !w_redir & (w_occ < (PW+2)'(DEPTH));
  // control state: fetch PC, in-flight tag, queue pointers and count; redirect wins
  always_ff @(posedge w_clk or posedge w_rst)
    if (w_rst) begin
      r_fpc <= RESET_PC;
      r_inf <= 1'b0;
      r_ipc <= '0;
      r_rp  <= '0;
      r_wp  <= '0;
      r_cnt <= '0;
    end else if (w_redir) begin
      r_fpc <= {w_tpc[31:2], 2'b00};
      r_inf <= 1'b0;
      r_rp  <= '0;
      r_wp  <= '0;
      r_cnt <= '0;
    end else begin
      r_inf <= w_issue;
      if (w_issue) begin
        r_ipc <= r_fpc;
        r_fpc <= r_fpc + 32'd4;
      end
      if (w_enq) r_wp <= r_wp + PW'(1);
      if (w_qdeq) r_rp <= r_rp + PW'(1);
      r_cnt <= r_cnt + (PW+1)'(w_enq) - (PW+1)'(w_qdeq);
    end
  // queue storage is not reset; validity is tracked by the count alone
  always_ff @(posedge w_clk)
    if (w_enq) begin
      r_ir[r_wp]  <= w_idata;
      r_pc[r_wp]  <= r_ipc;
      r_pc4[r_wp] <= r_ipc + 32'd4;
    end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed checks of fetch queue streaming, backpressure, redirect, halt, wrap, async reset
module tb_inst_fetch_queue;
  logic        w_clk = 1'b0, w_rst = 1'b0, w_redir = 1'b0, w_halt = 1'b0, w_dready = 1'b0;
  logic [31:0] w_tpc = '0, w_idata, w_dir, w_dpc, w_dpc4, r_fpc;
  logic [11:0] w_iaddr;
  logic        w_dvalid;
  logic [31:0] w2_idata, w2_dir, w2_dpc, w2_dpc4, r2_fpc;
  logic [11:0] w2_iaddr;
  logic        w2_dvalid;
  int pass = 0, total = 0;

  inst_fetch_queue u_dut (
    .w_clk(w_clk), .w_rst(w_rst), .w_redir(w_redir), .w_tpc(w_tpc), .w_halt(w_halt),
    .w_iaddr(w_iaddr), .w_idata(w_idata), .w_dvalid(w_dvalid), .w_dir(w_dir),
    .w_dpc(w_dpc), .w_dpc4(w_dpc4), .w_dready(w_dready), .r_fpc(r_fpc));

  inst_fetch_queue #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .w_clk(w_clk), .w_rst(w_rst), .w_redir(1'b0), .w_tpc(32'h0), .w_halt(1'b0),
    .w_iaddr(w2_iaddr), .w_idata(w2_idata), .w_dvalid(w2_dvalid), .w_dir(w2_dir),
    .w_dpc(w2_dpc), .w_dpc4(w2_dpc4), .w_dready(1'b1), .r_fpc(r2_fpc));

  always #5 w_clk = ~w_clk;
  // synchronous-read imem whose word k holds the value k
  always_ff @(posedge w_clk) begin
    w_idata  <= 32'(w_iaddr);
    w2_idata <= 32'(w2_iaddr);
  end

  task automatic cyc;
    @(posedge w_clk);
    #2;
  endtask

  task automatic rst_pulse;
    w_rst = 1'b1;
    #1;
    w_rst = 1'b0;
  endtask

  task automatic test_reset;
    w_rst = 1'b1;
    #1;
    total++; if (w_dvalid !== 1'b0) $display("FAIL reset_dvalid: got %b want 0", w_dvalid); else pass++;
    total++; if (r_fpc !== 32'h0) $display("FAIL reset_fpc: got %h want 0", r_fpc); else pass++;
    total++; if (w_iaddr !== 12'h0) $display("FAIL reset_iaddr: got %h want 0", w_iaddr); else pass++;
    total++; if (r2_fpc !== 32'hFFFF_FFF8 || w2_iaddr !== 12'hFFE)
      $display("FAIL reset_wrap_pc: got fpc=%h iaddr=%h want fffffff8/ffe", r2_fpc, w2_iaddr); else pass++;
    w_rst = 1'b0;
  endtask

  task automatic test_stream;
    rst_pulse();
    w_dready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      total++;
      if (n < 2 ? (w_dvalid !== 1'b0)
                : (w_dvalid !== 1'b1 || w_dir !== 32'(n-2) || w_dpc !== 32'(4*(n-2)) || w_dpc4 !== 32'(4*(n-1))))
        $display("FAIL stream_c%0d: got v=%b dir=%h dpc=%h dpc4=%h want v=%0d dir=%0d", n, w_dvalid, w_dir, w_dpc, w_dpc4, n >= 2, n-2);
      else pass++;
      total++;
      if (r_fpc !== 32'(4*n) || w_iaddr !== 12'(n))
        $display("FAIL stream_fpc_c%0d: got fpc=%h iaddr=%h want %h", n, r_fpc, w_iaddr, 4*n);
      else pass++;
      cyc();
    end
  endtask

  task automatic test_backpressure;
    rst_pulse();
    w_dready = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (n >= 5) begin
        total++;
        if (r_fpc !== 32'h10 || w_dvalid !== 1'b1 || w_dir !== 32'h0)
          $display("FAIL bp_hold_c%0d: got fpc=%h v=%b dir=%h want 10/1/0", n, r_fpc, w_dvalid, w_dir);
        else pass++;
      end
      cyc();
    end
    w_dready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      total++;
      if (w_dvalid !== 1'b1 || w_dir !== 32'(n) || w_dpc !== 32'(4*n))
        $display("FAIL bp_release_%0d: got v=%b dir=%h dpc=%h want dir=%0d", n, w_dvalid, w_dir, w_dpc, n);
      else pass++;
      cyc();
    end
  endtask

  task automatic test_redirect;
    rst_pulse();
    w_dready = 1'b1;
    repeat (4) cyc();
    total++; if (w_dvalid !== 1'b1 || w_dpc !== 32'h8) $display("FAIL redir_pre: got v=%b dpc=%h want 1/8", w_dvalid, w_dpc); else pass++;
    w_redir = 1'b1;
    w_tpc = 32'h43;
    cyc();
    w_redir = 1'b0;
    total++; if (w_dvalid !== 1'b0 || r_fpc !== 32'h40) $display("FAIL redir_t1: got v=%b fpc=%h want 0/40", w_dvalid, r_fpc); else pass++;
    cyc();
    total++; if (w_dvalid !== 1'b0) $display("FAIL redir_t2: got v=%b want 0", w_dvalid); else pass++;
    cyc();
    total++;
    if (w_dvalid !== 1'b1 || w_dpc !== 32'h40 || w_dpc4 !== 32'h44 || w_dir !== 32'h10)
      $display("FAIL redir_t3: got v=%b dpc=%h dpc4=%h dir=%h want 1/40/44/10", w_dvalid, w_dpc, w_dpc4, w_dir);
    else pass++;
    cyc();
    total++; if (w_dvalid !== 1'b1 || w_dpc !== 32'h44) $display("FAIL redir_t4: got v=%b dpc=%h want 1/44", w_dvalid, w_dpc); else pass++;
  endtask

  task automatic test_halt;
    rst_pulse();
    w_dready = 1'b0;
    repeat (3) cyc();
    w_dready = 1'b1;
    w_halt = 1'b1;
    for (int n = 0; n < 5; n++) begin
      total++;
      if (n < 3 ? (w_dvalid !== 1'b1 || w_dir !== 32'(n)) : (w_dvalid !== 1'b0))
        $display("FAIL halt_%0d: got v=%b dir=%h want v=%0d dir=%0d", n, w_dvalid, w_dir, n < 3, n);
      else pass++;
      total++; if (r_fpc !== 32'hC) $display("FAIL halt_fpc_%0d: got %h want c", n, r_fpc); else pass++;
      cyc();
    end
    w_halt = 1'b0;
  endtask

  task automatic test_wrap;
    rst_pulse();
    cyc();
    cyc();
    total++;
    if (w2_dvalid !== 1'b1 || w2_dpc !== 32'hFFFF_FFF8 || w2_dir !== 32'hFFE)
      $display("FAIL wrap_0: got v=%b dpc=%h dir=%h want 1/fffffff8/ffe", w2_dvalid, w2_dpc, w2_dir);
    else pass++;
    cyc();
    total++;
    if (w2_dvalid !== 1'b1 || w2_dpc !== 32'hFFFF_FFFC || w2_dpc4 !== 32'h0)
      $display("FAIL wrap_1: got v=%b dpc=%h dpc4=%h want 1/fffffffc/0", w2_dvalid, w2_dpc, w2_dpc4);
    else pass++;
    cyc();
    total++;
    if (w2_dvalid !== 1'b1 || w2_dpc !== 32'h0 || w2_dir !== 32'h0)
      $display("FAIL wrap_2: got v=%b dpc=%h dir=%h want 1/0/0", w2_dvalid, w2_dpc, w2_dir);
    else pass++;
  endtask

  task automatic test_async_reset;
    rst_pulse();
    w_dready = 1'b1;
    repeat (5) cyc();
    w_rst = 1'b1;
    #1;
    total++;
    if (w_dvalid !== 1'b0 || r_fpc !== 32'h0 || w_iaddr !== 12'h0)
      $display("FAIL async_rst: got v=%b fpc=%h iaddr=%h want 0/0/0", w_dvalid, r_fpc, w_iaddr);
    else pass++;
    w_rst = 1'b0;
    cyc();
    total++; if (w_dvalid !== 1'b0) $display("FAIL async_c1: got v=%b want 0", w_dvalid); else pass++;
    cyc();
    total++;
    if (w_dvalid !== 1'b1 || w_dpc !== 32'h0 || w_dir !== 32'h0)
      $display("FAIL async_c2: got v=%b dpc=%h dir=%h want 1/0/0", w_dvalid, w_dpc, w_dir);
    else pass++;
  endtask

  initial begin
    cyc();
    test_reset();
    cyc();
    test_stream();
    test_backpressure();
    test_redirect();
    cyc();
    test_halt();
    test_wrap();
    cyc();
    test_async_reset();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
